// File: rtl/alu_pkg.sv
// Shared types for the ALU issue buffer.
//   alu_op_e     : ALU opcode encoding (add .. slt); 14 and 15 are illegal.
//   buf_state_e  : occupancy of the two-entry skid buffer.
//   alu_entry_t  : one buffered instruction. Data/opcode fields are sized for the
//                  widest supported configuration; a module instance uses the low
//                  WIDTH / OP bits and keeps the rest at zero.
//   op_is_illegal / op_is_branch : opcode classification helpers.
package alu_pkg;

    localparam int unsigned MaxWidth   = 64;
    localparam int unsigned MaxOpWidth = 8;

    typedef enum logic [3:0] {
        OpAdd = 4'd0,
        OpSub = 4'd1,
        OpSll = 4'd2,
        OpSla = 4'd3,
        OpSrl = 4'd4,
        OpSra = 4'd5,
        OpXor = 4'd6,
        OpOr  = 4'd7,
        OpAnd = 4'd8,
        OpBeq = 4'd9,
        OpBne = 4'd10,
        OpBlt = 4'd11,
        OpBge = 4'd12,
        OpSlt = 4'd13
    } alu_op_e;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } buf_state_e;

    typedef struct packed {
        logic [MaxWidth-1:0]   rs1;
        logic [MaxWidth-1:0]   rs2;
        logic [4:0]            rs1_addr;
        logic [4:0]            rs2_addr;
        logic                  use_imm;
        logic [4:0]            rd;
        logic [MaxOpWidth-1:0] op;
        logic                  illegal;
    } alu_entry_t;

    function automatic logic op_is_illegal(input logic [MaxOpWidth-1:0] op);
        return (op == MaxOpWidth'(4'd14)) || (op == MaxOpWidth'(4'd15));
    endfunction

    function automatic logic op_is_branch(input logic [MaxOpWidth-1:0] op);
        return (op >= MaxOpWidth'(OpBeq)) && (op <= MaxOpWidth'(OpBge));
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Operand bypass selector for one source operand.
//   enable              : 0 passes src_val through untouched (immediate operand).
//   src_addr, src_val   : architectural source index and its current value.
//   fwd_ex_*            : EX/MEM result bus (highest priority).
//   fwd_wb_*            : writeback result bus.
//   operand             : selected value.
// x0 never matches a bypass bus, so its register-file value is kept.
module operand_bypass #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             enable,
    input  logic [4:0]       src_addr,
    input  logic [WIDTH-1:0] src_val,
    input  logic             fwd_ex_valid,
    input  logic [4:0]       fwd_ex_rd,
    input  logic [WIDTH-1:0] fwd_ex_data,
    input  logic             fwd_wb_valid,
    input  logic [4:0]       fwd_wb_rd,
    input  logic [WIDTH-1:0] fwd_wb_data,
    output logic [WIDTH-1:0] operand
);

    always_comb begin
        operand = src_val;
        if (enable && (src_addr != 5'd0)) begin
            if (fwd_ex_valid && (fwd_ex_rd == src_addr)) begin
                operand = fwd_ex_data;
            end else if (fwd_wb_valid && (fwd_wb_rd == src_addr)) begin
                operand = fwd_wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue_buffer.sv
// Two-entry skid buffer between decode and the ALU.
//   clk, rst                : clock, asynchronous active-high reset.
//   in_valid / in_ready     : decode handshake; in_ready is registered.
//   in_rs*_val, in_*_addr   : register-file data and register indices.
//   in_op, in_imm, in_use_imm : opcode, immediate, immediate select for rs2.
//   fwd_ex_*, fwd_wb_*      : result bypass buses (EX/MEM has priority).
//   flush                   : squash everything held and any push this cycle.
//   out_valid / out_ready   : ALU handshake on the head entry.
//   alu_*, out_*            : head entry fields.
// Held operands are re-bypassed every cycle so a producer finishing after capture
// still reaches the waiting instruction. The same four bypass instances serve both
// capture and refresh: each slot's pre-bypass value is chosen first (hold, incoming,
// or the skid entry moving to the head) and then bypassed on the way into the flop.
module alu_issue_buffer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned OP    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_rs1_val,
    input  logic [WIDTH-1:0] in_rs2_val,
    input  logic [4:0]       in_rs1_addr,
    input  logic [4:0]       in_rs2_addr,
    input  logic [4:0]       in_rd_addr,
    input  logic [OP-1:0]    in_op,
    input  logic [WIDTH-1:0] in_imm,
    input  logic             in_use_imm,
    input  logic             fwd_ex_valid,
    input  logic [4:0]       fwd_ex_rd,
    input  logic [WIDTH-1:0] fwd_ex_data,
    input  logic             fwd_wb_valid,
    input  logic [4:0]       fwd_wb_rd,
    input  logic [WIDTH-1:0] fwd_wb_data,
    input  logic             flush,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_rs1,
    output logic [WIDTH-1:0] alu_rs2,
    output logic [OP-1:0]    alu_op,
    output logic [4:0]       alu_shifter_size,
    output logic [4:0]       out_rd,
    output logic             out_is_branch,
    output logic             out_illegal
);

    buf_state_e state_q, state_d;
    logic       in_ready_q;
    alu_entry_t ent0_q, ent0_d;
    alu_entry_t ent1_q, ent1_d;
    alu_entry_t in_entry;
    alu_entry_t raw0, raw1;

    logic [MaxOpWidth-1:0] in_op_ext;
    logic [WIDTH-1:0]      byp0_rs1, byp0_rs2, byp1_rs1, byp1_rs2;
    logic                  push, pop;

    assign push = in_valid && in_ready_q;
    assign pop  = out_valid && out_ready;

    // Incoming instruction before bypass; illegal opcodes become add + flag.
    always_comb begin
        in_op_ext            = '0;
        in_op_ext[OP-1:0]    = in_op;
        in_entry             = '0;
        in_entry.rs1[WIDTH-1:0] = in_rs1_val;
        in_entry.rs2[WIDTH-1:0] = in_use_imm ? in_imm : in_rs2_val;
        in_entry.rs1_addr    = in_rs1_addr;
        in_entry.rs2_addr    = in_rs2_addr;
        in_entry.use_imm     = in_use_imm;
        in_entry.rd          = in_rd_addr;
        if (op_is_illegal(in_op_ext)) begin
            in_entry.op      = '0;
            in_entry.illegal = 1'b1;
        end else begin
            in_entry.op      = in_op_ext;
            in_entry.illegal = 1'b0;
        end
    end

    // Occupancy FSM and pre-bypass slot sources.
    always_comb begin
        state_d = state_q;
        raw0    = ent0_q;
        raw1    = ent1_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                    raw0    = in_entry;
                end
            end
            StOne: begin
                if (push && pop) begin
                    raw0 = in_entry;
                end else if (push) begin
                    state_d = StTwo;
                    raw1    = in_entry;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StTwo: begin
                // in_ready is low here, so no push can arrive.
                if (pop) begin
                    state_d = StOne;
                    raw0    = ent1_q;
                end
            end
            default: state_d = StEmpty;
        endcase
        if (flush) begin
            state_d = StEmpty;
        end
    end

    operand_bypass #(.WIDTH(WIDTH)) u_byp_e0_rs1 (
        .enable       (1'b1),
        .src_addr     (raw0.rs1_addr),
        .src_val      (raw0.rs1[WIDTH-1:0]),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_rd    (fwd_ex_rd),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_wb_valid (fwd_wb_valid),
        .fwd_wb_rd    (fwd_wb_rd),
        .fwd_wb_data  (fwd_wb_data),
        .operand      (byp0_rs1)
    );

    operand_bypass #(.WIDTH(WIDTH)) u_byp_e0_rs2 (
        .enable       (!raw0.use_imm),
        .src_addr     (raw0.rs2_addr),
        .src_val      (raw0.rs2[WIDTH-1:0]),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_rd    (fwd_ex_rd),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_wb_valid (fwd_wb_valid),
        .fwd_wb_rd    (fwd_wb_rd),
        .fwd_wb_data  (fwd_wb_data),
        .operand      (byp0_rs2)
    );

    operand_bypass #(.WIDTH(WIDTH)) u_byp_e1_rs1 (
        .enable       (1'b1),
        .src_addr     (raw1.rs1_addr),
        .src_val      (raw1.rs1[WIDTH-1:0]),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_rd    (fwd_ex_rd),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_wb_valid (fwd_wb_valid),
        .fwd_wb_rd    (fwd_wb_rd),
        .fwd_wb_data  (fwd_wb_data),
        .operand      (byp1_rs1)
    );

    operand_bypass #(.WIDTH(WIDTH)) u_byp_e1_rs2 (
        .enable       (!raw1.use_imm),
        .src_addr     (raw1.rs2_addr),
        .src_val      (raw1.rs2[WIDTH-1:0]),
        .fwd_ex_valid (fwd_ex_valid),
        .fwd_ex_rd    (fwd_ex_rd),
        .fwd_ex_data  (fwd_ex_data),
        .fwd_wb_valid (fwd_wb_valid),
        .fwd_wb_rd    (fwd_wb_rd),
        .fwd_wb_data  (fwd_wb_data),
        .operand      (byp1_rs2)
    );

    always_comb begin
        ent0_d                  = raw0;
        ent0_d.rs1[WIDTH-1:0]   = byp0_rs1;
        ent0_d.rs2[WIDTH-1:0]   = byp0_rs2;
        ent1_d                  = raw1;
        ent1_d.rs1[WIDTH-1:0]   = byp1_rs1;
        ent1_d.rs2[WIDTH-1:0]   = byp1_rs2;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StEmpty;
            in_ready_q <= 1'b1;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != StTwo);
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign out_valid        = (state_q != StEmpty);
    assign alu_rs1          = ent0_q.rs1[WIDTH-1:0];
    assign alu_rs2          = ent0_q.rs2[WIDTH-1:0];
    assign alu_shifter_size = ent0_q.rs2[4:0];
    assign alu_op           = ent0_q.op[OP-1:0];
    assign out_rd           = ent0_q.rd;
    assign out_is_branch    = op_is_branch(ent0_q.op);
    assign out_illegal      = ent0_q.illegal;

endmodule
